// File: rtl/ir_nec_decoder.sv
// rtl/ir_nec_decoder.sv - NEC IR frame decoder producing a 3-bit motion code
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   ir_in          raw IR receiver output, asynchronous, low = mark
//   state_control  current motion code (returns to STOP after RELEASE_TICKS of silence)
//   cmd            last valid command byte
//   addr           last valid address byte
//   frame_valid    one-cycle pulse on a valid full frame
//   repeat_valid   one-cycle pulse on a valid repeat code
//   frame_error    one-cycle pulse on a malformed frame
module ir_nec_decoder #(
  parameter int         TICK_CYCLES   = 500,
  parameter int         RELEASE_TICKS = 12000,
  parameter logic [7:0] CMD_LEFT      = 8'h08,
  parameter logic [7:0] CMD_RIGHT     = 8'h5A,
  parameter logic [7:0] CMD_SLOW      = 8'h18,
  parameter logic [7:0] CMD_MED       = 8'h52,
  parameter logic [7:0] CMD_FAST      = 8'h4A,
  parameter logic [7:0] CMD_STOP      = 8'h1C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [2:0] state_control,
  output logic [7:0] cmd,
  output logic [7:0] addr,
  output logic       frame_valid,
  output logic       repeat_valid,
  output logic       frame_error
);

  localparam int              PW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [13:0]     REL_MAX = 14'(RELEASE_TICKS);

  // Pulse-width windows in 10 us ticks, inclusive.
  localparam logic [10:0] LEAD_MARK_LO  = 11'd800;
  localparam logic [10:0] LEAD_MARK_HI  = 11'd1000;
  localparam logic [10:0] LEAD_SPACE_LO = 11'd400;
  localparam logic [10:0] LEAD_SPACE_HI = 11'd500;
  localparam logic [10:0] RPT_SPACE_LO  = 11'd200;
  localparam logic [10:0] RPT_SPACE_HI  = 11'd250;
  localparam logic [10:0] BIT_MARK_LO   = 11'd40;
  localparam logic [10:0] BIT_MARK_HI   = 11'd70;
  localparam logic [10:0] ZERO_LO       = 11'd40;
  localparam logic [10:0] ZERO_HI       = 11'd70;
  localparam logic [10:0] ONE_LO        = 11'd140;
  localparam logic [10:0] ONE_HI        = 11'd190;
  localparam logic [10:0] TIMEOUT       = 11'd1100;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK, TRAIL
  } state_t;

  state_t        state;
  logic          ir_s1, ir_s2, ir_d;
  logic          fall, rise;
  logic [PW-1:0] pre, rel_pre;
  logic [10:0]   tick_cnt;
  logic [13:0]   rel_cnt;
  logic [31:0]   shreg;
  logic [4:0]    bit_cnt;
  logic          have_frame;
  logic          timeout;
  logic          rel_strobe;
  logic          is_zero, is_one;
  logic          check_ok;

  function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Synchronizer idles high so reset never manufactures a fall edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_s1 <= 1'b1;
      ir_s2 <= 1'b1;
      ir_d  <= 1'b1;
    end else begin
      ir_s1 <= ir_in;
      ir_s2 <= ir_s1;
      ir_d  <= ir_s2;
    end
  end

  assign fall = ir_d & ~ir_s2;
  assign rise = ~ir_d & ir_s2;

  // Duration of the current mark/space; restarts on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      tick_cnt <= '0;
    end else if (fall || rise) begin
      pre      <= '0;
      tick_cnt <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      if (tick_cnt != 11'h7FF) tick_cnt <= tick_cnt + 11'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Free-running 10 us strobe for the key-release timer, independent of edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel_pre <= '0;
    else if (rel_pre == PRE_MAX) rel_pre <= '0;
    else rel_pre <= rel_pre + PW'(1);
  end

  assign rel_strobe = (rel_pre == PRE_MAX);
  assign timeout    = (tick_cnt >= TIMEOUT);
  assign is_zero    = in_win(tick_cnt, ZERO_LO, ZERO_HI);
  assign is_one     = in_win(tick_cnt, ONE_LO, ONE_HI);
  // Bits arrive LSB first, so byte0 (address) ends up in shreg[7:0].
  assign check_ok   = ((shreg[7:0] ^ shreg[15:8]) == 8'hFF) &&
                      ((shreg[23:16] ^ shreg[31:24]) == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      state_control <= 3'b000;
      cmd           <= 8'h00;
      addr          <= 8'h00;
      frame_valid   <= 1'b0;
      repeat_valid  <= 1'b0;
      frame_error   <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      have_frame    <= 1'b0;
      rel_cnt       <= REL_MAX;
    end else begin
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      frame_error  <= 1'b0;

      // Release timer; a frame or repeat below overrides this by clearing it.
      if (rel_strobe && rel_cnt != REL_MAX) begin
        rel_cnt <= rel_cnt + 14'd1;
        if (rel_cnt + 14'd1 == REL_MAX) state_control <= 3'b000;
      end

      // Edges are tested before timeout so an edge in the timeout cycle wins.
      case (state)
        IDLE: begin
          if (fall) state <= LEAD_MARK;
        end
        LEAD_MARK: begin
          if (rise) begin
            state <= in_win(tick_cnt, LEAD_MARK_LO, LEAD_MARK_HI) ? LEAD_SPACE : IDLE;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        LEAD_SPACE: begin
          if (fall) begin
            if (in_win(tick_cnt, LEAD_SPACE_LO, LEAD_SPACE_HI)) begin
              bit_cnt <= '0;
              state   <= BIT_MARK;
            end else if (in_win(tick_cnt, RPT_SPACE_LO, RPT_SPACE_HI)) begin
              if (have_frame) begin
                repeat_valid <= 1'b1;
                rel_cnt      <= '0;
              end
              state <= TRAIL;
            end else begin
              frame_error <= 1'b1;
              state       <= IDLE;
            end
          end else if (timeout) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        BIT_MARK: begin
          if (rise) begin
            if (in_win(tick_cnt, BIT_MARK_LO, BIT_MARK_HI)) begin
              state <= BIT_SPACE;
            end else begin
              frame_error <= 1'b1;
              state       <= IDLE;
            end
          end else if (timeout) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        BIT_SPACE: begin
          if (fall) begin
            if (is_zero || is_one) begin
              shreg <= {is_one, shreg[31:1]};
              if (bit_cnt == 5'd31) begin
                state <= CHECK;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                state   <= BIT_MARK;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= IDLE;
            end
          end else if (timeout) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        CHECK: begin
          if (check_ok) begin
            addr        <= shreg[7:0];
            cmd         <= shreg[23:16];
            frame_valid <= 1'b1;
            have_frame  <= 1'b1;
            rel_cnt     <= '0;
            // Unmapped commands still count as valid frames but leave the code alone.
            case (shreg[23:16])
              CMD_STOP:  state_control <= 3'b000;
              CMD_LEFT:  state_control <= 3'b001;
              CMD_RIGHT: state_control <= 3'b010;
              CMD_SLOW:  state_control <= 3'b011;
              CMD_MED:   state_control <= 3'b100;
              CMD_FAST:  state_control <= 3'b101;
              default:   ;
            endcase
          end else begin
            frame_error <= 1'b1;
          end
          state <= TRAIL;
        end
        TRAIL: begin
          if (rise || timeout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb/tb_ir_nec_decoder.sv - directed self-checking bench for ir_nec_decoder
//
// One tick is one clock here (TICK_CYCLES=1); durations below are in ticks
// of 10 us. The release window is shortened to 8000 ticks and the repeat
// period to 5000 ticks so the whole run stays short.
module tb_ir_nec_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir_in = 1'b1;
  logic [2:0] state_control;
  logic [7:0] cmd;
  logic [7:0] addr;
  logic       frame_valid;
  logic       repeat_valid;
  logic       frame_error;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_fv = 0, n_rv = 0, n_fe = 0, n_multi = 0;
  int rv_cyc = 0, fe_cyc = 0;
  int s_fv, s_rv, s_fe;
  int t_edge;
  int lat;

  ir_nec_decoder #(
    .TICK_CYCLES  (1),
    .RELEASE_TICKS(8000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_in        (ir_in),
    .state_control(state_control),
    .cmd          (cmd),
    .addr         (addr),
    .frame_valid  (frame_valid),
    .repeat_valid (repeat_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) n_fv <= n_fv + 1;
    if (repeat_valid) begin
      n_rv   <= n_rv + 1;
      rv_cyc <= cyc;
    end
    if (frame_error) begin
      n_fe   <= n_fe + 1;
      fe_cyc <= cyc;
    end
    if (32'(frame_valid) + 32'(repeat_valid) + 32'(frame_error) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    ir_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_leader();
    hold(1'b0, 900);
    hold(1'b1, 450);
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 56);
      hold(1'b1, d[i] ? 169 : 56);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ci);
    send_leader();
    send_bits({ci, c, ~a, a}, 32);
    hold(1'b0, 56);
    hold(1'b1, 100);
  endtask

  task automatic send_repeat();
    hold(1'b0, 900);
    hold(1'b1, 225);
    hold(1'b0, 56);
    hold(1'b1, 100);
  endtask

  task automatic snap();
    s_fv = n_fv;
    s_rv = n_rv;
    s_fe = n_fe;
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_sc", 32'(state_control), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h00);
    chk("rst_addr", 32'(addr), 32'h00);
    chk("rst_pulses", 32'({frame_valid, repeat_valid, frame_error}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_sc", 32'(state_control), 32'd0);

    // Nominal LEFT frame
    snap();
    send_frame(8'h00, 8'h08, 8'hF7);
    chk("left_fv", n_fv - s_fv, 1);
    chk("left_fe", n_fe - s_fe, 0);
    chk("left_cmd", 32'(cmd), 32'h08);
    chk("left_addr", 32'(addr), 32'h00);
    chk("left_sc", 32'(state_control), 32'd1);

    // Same frame with corrupted cmd inverse
    snap();
    send_frame(8'h00, 8'h08, 8'hF6);
    chk("bad_fe", n_fe - s_fe, 1);
    chk("bad_fv", n_fv - s_fv, 0);
    chk("bad_sc", 32'(state_control), 32'd1);

    // FAST frame followed by repeats, then release
    snap();
    send_frame(8'h10, 8'h4A, 8'hB5);
    chk("fast_fv", n_fv - s_fv, 1);
    chk("fast_sc", 32'(state_control), 32'd5);
    for (int r = 1; r <= 4; r++) begin
      send_repeat();
      chk("rpt_cnt", n_rv - s_rv, r);
      chk("rpt_sc", 32'(state_control), 32'd5);
      hold(1'b1, 5000 - 1281);
    end
    while (cyc < rv_cyc + 7999) @(negedge clk);
    chk("rel_before", 32'(state_control), 32'd5);
    while (cyc < rv_cyc + 8002) @(negedge clk);
    chk("rel_after", 32'(state_control), 32'd0);
    chk("rel_cmd", 32'(cmd), 32'h4A);

    // Short low glitch on an idle line
    snap();
    hold(1'b0, 300);
    hold(1'b1, 100);
    chk("gl_pulses", (n_fv - s_fv) + (n_rv - s_rv) + (n_fe - s_fe), 0);
    chk("gl_sc", 32'(state_control), 32'd0);
    chk("gl_cmd", 32'(cmd), 32'h4A);
    chk("gl_addr", 32'(addr), 32'h10);

    // Stalled frame: line held high after bit 10's mark
    snap();
    send_leader();
    send_bits({8'hA5, 8'h5A, 8'hC3, 8'h3C}, 10);
    hold(1'b0, 56);
    ir_in = 1'b1;
    t_edge = cyc;
    repeat (1500) @(negedge clk);
    lat = fe_cyc - t_edge;
    chk("to_fe", n_fe - s_fe, 1);
    chk("to_fv", n_fv - s_fv, 0);
    chk("to_lat", 32'(lat >= 1100 && lat <= 1110), 32'd1);

    // RIGHT frame decodes after the timeout
    snap();
    send_frame(8'h3C, 8'h5A, 8'hA5);
    chk("right_fv", n_fv - s_fv, 1);
    chk("right_sc", 32'(state_control), 32'd2);
    chk("right_cmd", 32'(cmd), 32'h5A);
    chk("right_addr", 32'(addr), 32'h3C);

    // Reset during bit 20 of a MED frame
    send_leader();
    send_bits({8'hAD, 8'h52, 8'hDE, 8'h21}, 20);
    hold(1'b0, 30);
    rst = 1'b1;
    ir_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_sc", 32'(state_control), 32'd0);
    chk("mrst_cmd", 32'(cmd), 32'h00);
    chk("mrst_addr", 32'(addr), 32'h00);
    chk("mrst_pulses", 32'({frame_valid, repeat_valid, frame_error}), 32'd0);
    rst = 1'b0;
    hold(1'b1, 200);
    snap();
    send_frame(8'h21, 8'h52, 8'hAD);
    chk("med_fv", n_fv - s_fv, 1);
    chk("med_fe", n_fe - s_fe, 0);
    chk("med_sc", 32'(state_control), 32'd4);
    chk("med_cmd", 32'(cmd), 32'h52);
    chk("med_addr", 32'(addr), 32'h21);

    chk("pulse_excl", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
# ir_nec_decoder

Decodes the raw demodulated output of a 38 kHz IR receiver (NEC protocol) into the 3-bit `state_control` motion code consumed by the JSON-over-UART transmitter stage. Sits directly upstream of that stage: remote key press → NEC frame → validated command byte → motion code, held while the key is held and released to STOP when the remote goes quiet.

## Interface
Parameters:
- `TICK_CYCLES`, 500: clk cycles per 10 µs measurement tick (50 MHz clk).
- `RELEASE_TICKS`, 12000: ticks (120 ms) without a valid frame or repeat before `state_control` returns to STOP.
- `CMD_LEFT`, 8'h08: maps to 3'b001.
- `CMD_RIGHT`, 8'h5A: maps to 3'b010.
- `CMD_SLOW`, 8'h18: maps to 3'b011.
- `CMD_MED`, 8'h52: maps to 3'b100.
- `CMD_FAST`, 8'h4A: maps to 3'b101.
- `CMD_STOP`, 8'h1C: maps to 3'b000.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `ir_in`, in, 1: raw receiver output, asynchronous, active-low (low = mark).
- `state_control`, out, 3: current motion code.
- `cmd`, out, 8: last valid command byte.
- `addr`, out, 8: last valid address byte.
- `frame_valid`, out, 1: one-cycle pulse on a valid full frame.
- `repeat_valid`, out, 1: one-cycle pulse on a valid repeat code.
- `frame_error`, out, 1: one-cycle pulse on a malformed frame.

## Operation
- `ir_in` passes through a 2-flop synchronizer; both flops reset to 1. Edges are detected on the synchronized signal: fall = mark start, rise = mark end.
- Duration measurement uses a prescaler counting 0..TICK_CYCLES-1 that drives an 11-bit tick counter saturating at 2047. Both counters clear on every synchronized edge.
- Windows, in ticks, inclusive: leader mark 800–1000; leader space 400–500; repeat space 200–250; bit mark 40–70; zero space 40–70; one space 140–190.
- FSM states and transitions:
  - IDLE: fall → LEAD_MARK.
  - LEAD_MARK: on rise, in window → LEAD_SPACE; otherwise → IDLE silently (glitch rejection).
  - LEAD_SPACE: on fall, space in the leader window → BIT_MARK with bit count 0; in the repeat window → pulse `repeat_valid` if a valid frame was previously decoded, then → TRAIL; any other length → `frame_error`, then → IDLE.
  - BIT_MARK: on rise, in window → BIT_SPACE; otherwise → error.
  - BIT_SPACE: on fall, the space is classified 0 or 1 and shifted in LSB-first into a 32-bit register. Any other length → error. After bit 31 → CHECK; else → BIT_MARK.
  - CHECK (1 cycle): byte0 = addr, byte1 = ~addr, byte2 = cmd, byte3 = ~cmd. If byte0^byte1 == 8'hFF and byte2^byte3 == 8'hFF, load `addr`/`cmd`, pulse `frame_valid`, and update `state_control` per the mapping. An unmapped cmd leaves `state_control` unchanged but still pulses `frame_valid`. A failed check → `frame_error`, nothing updated. Then → TRAIL.
  - TRAIL: rise → IDLE.
- Timeout: in any state other than IDLE, a tick count reaching 1100 → IDLE. This raises `frame_error` except in LEAD_MARK and TRAIL.
- Release: a separate free-running 10 µs strobe drives a 14-bit release counter. The counter clears on `frame_valid` or `repeat_valid`. On reaching RELEASE_TICKS, `state_control` ← 3'b000 and the counter holds.
- Simultaneous edge and timeout in the same cycle: the edge wins.

## Timing
- Reset values: `state_control`=3'b000, `cmd`=8'h00, `addr`=8'h00, all pulses 0, FSM IDLE, all counters 0, release counter saturated (STOP).
- Reset asserted mid-frame: everything returns to reset values immediately. A partially received frame is discarded, and the first edge after reset release is treated as a new frame.
- Latency: `frame_valid`, `cmd`, `addr` and `state_control` update 2 sync cycles + 1 edge-detect cycle + 1 CHECK cycle after the raw `ir_in` fall that ends bit 31's space. `state_control` and `cmd` change in the same cycle `frame_valid` is high.
- Outputs hold between updates. Pulses are exactly one cycle wide. At most one of the three pulses is high in any cycle.

## Test plan
- Full frame, addr 8'h00, cmd 8'h08, nominal timing (9 ms / 4.5 ms / 562 µs / 1687 µs) → one `frame_valid` pulse, `cmd`=8'h08, `addr`=8'h00, `state_control`=3'b001.
- Same frame with the cmd inverse byte corrupted (byte3 = 8'hF6) → one `frame_error` pulse, `state_control` stays at its prior value, no `frame_valid`.
- Valid CMD_FAST frame, then a repeat code (9 ms / 2.25 ms / 562 µs) every 108 ms for 500 ms → `repeat_valid` pulses each time, `state_control` holds at 3'b101 throughout; after the last repeat, it drops to 3'b000 exactly 120 ms ± 10 µs later.
- 3 ms low glitch on an idle line → no pulses, FSM back in IDLE, outputs unchanged.
- Leader, then the line held high for 15 ms after bit 10 → `frame_error` at the timeout (11 ms after the last edge), then a following valid CMD_RIGHT frame decodes to 3'b010.
- `rst` asserted during bit 20 of a CMD_MED frame → all outputs at reset values; the next complete CMD_MED frame yields 3'b100.
